// File: rtl/axis_bram_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_bram_capture_pkg
// Description : State encoding shared by the capture sequencer.
// Revision    : 1.0
// ============================================================================
package axis_bram_capture_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRE   = 3'd1;
    localparam logic [STATE_W-1:0] ST_ARMED = 3'd2;
    localparam logic [STATE_W-1:0] ST_POST  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_PRE   = ST_PRE,
        S_ARMED = ST_ARMED,
        S_POST  = ST_POST,
        S_DONE  = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_bram_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axis_bram_capture_ctrl
// Description : Triggered AXI4-Stream to BRAM capture with circular pre-trigger
//               history and a fixed post-trigger window.
// Revision    : 1.0
// ============================================================================
module axis_bram_capture_ctrl
    import axis_bram_capture_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_pre,
    input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_post,
    input  logic                         ctl_start,
    input  logic                         ctl_abort,
    input  logic                         trg_in,
    output logic [STATE_W-1:0]           sts_state,
    output logic                         sts_busy,
    output logic                         sts_done,
    output logic [BRAM_ADDR_WIDTH-1:0]   sts_trig_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]   sts_start_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic                         b_bram_clk,
    output logic                         b_bram_rst,
    output logic                         b_bram_en,
    output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata
);

    localparam logic [BRAM_ADDR_WIDTH-1:0] C_ONE  = BRAM_ADDR_WIDTH'(1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] C_ZERO = '0;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0]  r_addr;
    logic [BRAM_ADDR_WIDTH-1:0]  r_cnt;
    logic [BRAM_ADDR_WIDTH-1:0]  r_pre;
    logic [BRAM_ADDR_WIDTH-1:0]  r_post;
    logic [BRAM_ADDR_WIDTH-1:0]  r_trig_addr;
    logic [BRAM_ADDR_WIDTH-1:0]  r_start_addr;
    logic                        w_busy;
    logic                        w_wr;
    logic                        w_start;
    logic                        w_trig;

    assign w_busy  = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    // Abort suppresses the write in its own cycle, not just from the next one.
    assign w_wr    = s_axis_tvalid & w_busy & ~ctl_abort;
    assign w_start = ctl_start & ~ctl_abort & ~w_busy;
    assign w_trig  = w_wr & trg_in & (r_state == S_ARMED);

    always_comb begin
        w_state_nxt = r_state;
        if (ctl_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (ctl_start) w_state_nxt = (cfg_pre != C_ZERO) ? S_PRE : S_ARMED;
                end
                S_PRE: begin
                    if (w_wr && (r_cnt == r_pre - C_ONE)) w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (w_trig) w_state_nxt = (r_post != C_ZERO) ? S_POST : S_DONE;
                end
                S_POST: begin
                    if (w_wr && (r_cnt == r_post - C_ONE)) w_state_nxt = S_DONE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_pre        <= '0;
            r_post       <= '0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_addr <= '0;
                r_cnt  <= '0;
                r_pre  <= cfg_pre;
                r_post <= cfg_post;
            end else if (w_wr) begin
                r_addr <= r_addr + C_ONE;
                if (w_trig) begin
                    r_cnt        <= '0;
                    r_trig_addr  <= r_addr;
                    r_start_addr <= r_addr - r_pre;
                end else if (r_state != S_ARMED) begin
                    r_cnt <= r_cnt + C_ONE;
                end
            end
        end
    end

    assign sts_state      = r_state;
    assign sts_busy       = w_busy;
    assign sts_done       = (r_state == S_DONE);
    assign sts_trig_addr  = r_trig_addr;
    assign sts_start_addr = r_start_addr;

    assign s_axis_tready  = 1'b1;
    assign b_bram_clk     = aclk;
    assign b_bram_rst     = areset;
    assign b_bram_en      = w_wr;
    assign b_bram_we      = {(BRAM_DATA_WIDTH/8){w_wr}};
    assign b_bram_addr    = r_addr;
    assign b_bram_wdata   = s_axis_tdata;

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_bram_capture_ctrl
// Description : Randomized self-checking bench with a beat-counting model.
// Revision    : 1.0
// ============================================================================
module tb_axis_bram_capture_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic          aclk = 1'b0;
    logic          areset = 1'b0;
    logic [AW-1:0] cfg_pre = '0;
    logic [AW-1:0] cfg_post = '0;
    logic          ctl_start = 1'b0;
    logic          ctl_abort = 1'b0;
    logic          trg_in = 1'b0;
    logic [2:0]    sts_state;
    logic          sts_busy;
    logic          sts_done;
    logic [AW-1:0] sts_trig_addr;
    logic [AW-1:0] sts_start_addr;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          b_bram_clk;
    logic          b_bram_rst;
    logic          b_bram_en;
    logic [DW/8-1:0] b_bram_we;
    logic [AW-1:0] b_bram_addr;
    logic [DW-1:0] b_bram_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_trig  = 0;
    int exp_start = 0;

    axis_bram_capture_ctrl #(
        .AXIS_TDATA_WIDTH(DW),
        .BRAM_DATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH (AW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_pre       (cfg_pre),
        .cfg_post      (cfg_post),
        .ctl_start     (ctl_start),
        .ctl_abort     (ctl_abort),
        .trg_in        (trg_in),
        .sts_state     (sts_state),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_trig_addr (sts_trig_addr),
        .sts_start_addr(sts_start_addr),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .b_bram_clk    (b_bram_clk),
        .b_bram_rst    (b_bram_rst),
        .b_bram_en     (b_bram_en),
        .b_bram_we     (b_bram_we),
        .b_bram_addr   (b_bram_addr),
        .b_bram_wdata  (b_bram_wdata)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int modn(input int v);
        return ((v % N) + N) % N;
    endfunction

    task automatic check_status(input int st);
        check("sts_state", 32'(sts_state), 32'(st));
        check("sts_busy", 32'(sts_busy), 32'(st >= 1 && st <= 3));
        check("sts_done", 32'(sts_done), 32'(st == 4));
        check("trig_addr", 32'(sts_trig_addr), 32'(exp_trig));
        check("start_addr", 32'(sts_start_addr), 32'(exp_start));
    endtask

    // The model only counts accepted beats: beat k lands at k mod N, the first
    // triggering beat at or after index pre ends the history, post more follow.
    task automatic run_capture(input int pre, input int post, input int vpct,
                               input int trig_beat, input bit pre_noise,
                               input bit rnd_trg, input int abort_cyc,
                               input int rst_cyc, input int start_cyc);
        int  k, tk, cyc, extra, st;
        bit  aborted, tv, trg, exp_en;
        logic [DW-1:0] d;
        k = 0; tk = -1; aborted = 0; extra = 0; cyc = 0;

        @(posedge aclk); #1;
        cfg_pre = AW'(pre); cfg_post = AW'(post); ctl_start = 1'b1; ctl_abort = 1'b0;
        s_axis_tvalid = 1'($urandom); trg_in = 1'($urandom); s_axis_tdata = $urandom;
        @(negedge aclk);
        check("start_cycle_en", 32'(b_bram_en), 32'd0);
        @(posedge aclk); #1;
        ctl_start = 1'b0;
        cfg_pre = AW'($urandom); cfg_post = AW'($urandom);

        while (1) begin
            if (aborted) st = 0;
            else if (tk >= 0 && k > tk + post) st = 4;
            else if (tk >= 0) st = 3;
            else if (k < pre) st = 1;
            else st = 2;

            tv  = ($urandom_range(99) < 32'(vpct));
            d   = $urandom;
            trg = (k == trig_beat) || (pre_noise && k < pre) || (rnd_trg && ($urandom_range(5) == 0));
            if (!tv) trg = 1'($urandom);
            s_axis_tvalid = tv; s_axis_tdata = d; trg_in = trg;
            ctl_abort = (cyc == abort_cyc);
            ctl_start = (cyc == start_cyc) && (st >= 1 && st <= 3) && (cyc != abort_cyc);

            if (cyc == rst_cyc) begin
                #1 areset = 1'b1;
                #1;
                exp_trig = 0; exp_start = 0; aborted = 1'b1; st = 0;
                check_status(0);
                check("rst_en", 32'(b_bram_en), 32'd0);
                check("rst_addr", 32'(b_bram_addr), 32'd0);
                #1 areset = 1'b0;
            end

            @(negedge aclk);
            check("state", 32'(sts_state), 32'(st));
            exp_en = tv && (st >= 1 && st <= 3) && (cyc != abort_cyc) && !aborted;
            check("en", 32'(b_bram_en), 32'(exp_en));
            if (exp_en) begin
                check("addr", 32'(b_bram_addr), 32'(modn(k)));
                check("wdata", b_bram_wdata, d);
                check("we", 32'(b_bram_we), 32'hF);
            end

            if (cyc == abort_cyc) aborted = 1'b1;
            else if (exp_en) begin
                if (tk < 0 && k >= pre && trg) begin
                    tk = k;
                    exp_trig  = modn(k);
                    exp_start = modn(k - pre);
                end
                k++;
            end

            if (aborted || (tk >= 0 && k > tk + post)) extra++;
            cyc++;
            @(posedge aclk); #1;
            ctl_abort = 1'b0; ctl_start = 1'b0;
            if (extra > 3) break;
            if (cyc > 6000) begin
                check("cycle_budget", 32'(cyc), 32'd0);
                break;
            end
        end
        @(negedge aclk);
        check_status(aborted ? 0 : 4);
        check("tready", 32'(s_axis_tready), 32'd1);
        @(posedge aclk); #1;
    endtask

    initial begin
        #2 areset = 1'b1;
        #1;
        check_status(0);
        check("rst_en", 32'(b_bram_en), 32'd0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check_status(0);

        // Nominal window, trigger at beat 10
        run_capture(4, 3, 100, 10, 0, 0, -1, -1, -1);
        check("t2_trig", 32'(sts_trig_addr), 32'd10);
        check("t2_start", 32'(sts_start_addr), 32'd6);
        // Trigger during history fill is ignored
        run_capture(4, 2, 100, 4, 1, 0, -1, -1, -1);
        check("t3_trig", 32'(sts_trig_addr), 32'd4);
        check("t3_start", 32'(sts_start_addr), 32'd0);
        // Zero-length history and window
        run_capture(0, 0, 100, 0, 0, 0, -1, -1, -1);
        check("t4_trig", 32'(sts_trig_addr), 32'd0);
        // Address wrap
        run_capture(8, 2, 100, 1030, 0, 0, -1, -1, -1);
        check("t5_trig", 32'(sts_trig_addr), 32'd6);
        check("t5_start", 32'(sts_start_addr), 32'd1022);
        // Gapped stream
        run_capture(3, 5, 33, 6, 0, 0, -1, -1, -1);

        // Start and abort together from DONE, then from IDLE
        repeat (2) begin
            ctl_start = 1'b1; ctl_abort = 1'b1; cfg_pre = 10'd2; s_axis_tvalid = 1'b1;
            @(negedge aclk);
            check("sa_en", 32'(b_bram_en), 32'd0);
            @(posedge aclk); #1;
            ctl_start = 1'b0; ctl_abort = 1'b0;
            @(negedge aclk);
            check_status(0);
            check("sa_idle_en", 32'(b_bram_en), 32'd0);
            @(posedge aclk); #1;
        end

        // Reset mid-window
        run_capture(2, 20, 100, 3, 0, 0, -1, 9, -1);
        // Abort mid-capture keeps previous status addresses
        run_capture(5, 6, 80, -1, 0, 1, 12, -1, 4);

        for (int r = 0; r < 10; r++) begin
            run_capture($urandom_range(15), $urandom_range(15), $urandom_range(100, 30),
                        -1, 1'($urandom), 1'b1,
                        ($urandom_range(3) == 0) ? $urandom_range(40) : -1,
                        -1, $urandom_range(30));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
